speicher_arbiter: RTL
=====================

Name: speicher_arbiter

Overview:
Parametrised memory arbiter that lets KANAELE requesters (CPU instruction ports, CPU data ports, DMA) share one memory port. Each channel uses the level-request / completion-pulse handshake the CPU already speaks (LeseInstruktion/InstruktionGeladen, LeseDaten/DatenGeladen, SchreibeDaten/DatenGespeichert). Grants are round-robin, one transaction at a time. A per-transaction timeout stops a requester hanging when memory never answers.

Parameters:
KANAELE, 2, number of requester channels (>=1)
DATEN_BREITE, 32, data width
ADRESS_BREITE, 32, address width
ZEITLIMIT, 255, max AKTIV cycles to wait for SpeicherFertig; 0 disables timeout

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high
LeseAnfrage  in  KANAELE  per-channel read request, level
SchreibAnfrage  in  KANAELE  per-channel write request, level
Adresse  in  KANAELE*ADRESS_BREITE  per-channel address; channel k at bits [k*ADRESS_BREITE +: ADRESS_BREITE]
SchreibDaten  in  KANAELE*DATEN_BREITE  per-channel write data, same packing
DatenRaus  out  DATEN_BREITE  read data of last completed read, registered
Geladen  out  KANAELE  one-cycle read-complete pulse per channel
Gespeichert  out  KANAELE  one-cycle write-complete pulse per channel
Fehler  out  KANAELE  one-cycle timeout pulse per channel
SpeicherAdresse  out  ADRESS_BREITE  memory address, registered
SpeicherSchreibDaten  out  DATEN_BREITE  memory write data, registered
SpeicherLesen  out  1  memory read strobe, level
SpeicherSchreiben  out  1  memory write strobe, level
SpeicherLeseDaten  in  DATEN_BREITE  memory read data, valid with SpeicherFertig
SpeicherFertig  in  1  memory completion, one-cycle pulse

Behaviour:
- Reset (async, any state): all outputs 0, state FREI, round-robin pointer = KANAELE-1 (channel 0 wins first), timeout counter 0.
- States: FREI, AKTIV, QUITTUNG. All outputs registered.
- FREI: channel k requests if LeseAnfrage[k]|SchreibAnfrage[k]. If no request, stay. Otherwise winner = first requesting channel after the pointer, scanning upward with wrap. Latch winner index, Adresse, SchreibDaten and operation; pointer := winner; next state AKTIV.
- Same channel with both requests: write served first. Read stays pending and is served in a later grant.
- AKTIV: SpeicherLesen or SpeicherSchreiben held high (exactly one). SpeicherAdresse and SpeicherSchreibDaten stay stable.
  - SpeicherFertig=1: drop strobe. On a read, DatenRaus := SpeicherLeseDaten. Next state QUITTUNG.
  - SpeicherFertig may arrive in the first AKTIV cycle (zero wait states).
- Timeout: counter cleared on entering AKTIV and incremented for each AKTIV cycle without SpeicherFertig. If ZEITLIMIT!=0 and the counter reaches ZEITLIMIT: drop strobe; on a read, DatenRaus := 0; Fehler flagged; next state QUITTUNG.
- QUITTUNG (exactly 1 cycle): Geladen[winner] (read) or Gespeichert[winner] (write) = 1. On timeout, Fehler[winner] = 1 in the same cycle as well. Next state FREI.
- Requester rule: deassert the served request at the clock edge that ends the pulse cycle. Requests are re-sampled in FREI only.
- Latency: request high in cycle 0, strobe from cycle 1; SpeicherFertig in cycle n gives the completion pulse in cycle n+1. Minimum request-to-pulse is 2 cycles, and 1 idle FREI cycle separates back-to-back transactions.
- SpeicherFertig outside AKTIV is ignored. Request changes during AKTIV/QUITTUNG do not affect the current transaction.
- DatenRaus holds its value until the next completed read.
- KANAELE=1: pointer logic degenerates; behaviour is otherwise identical.

Test Plan:
1. Ch0 read at addr 0x40; memory answers SpeicherFertig in the 3rd AKTIV cycle with 0xDEADBEEF -> SpeicherLesen high exactly 3 cycles, SpeicherAdresse=0x40, Geladen[0] one-cycle pulse with DatenRaus=0xDEADBEEF, Fehler=0.
2. Ch1 write addr 0x100 data 0x12345678, zero-wait memory -> SpeicherSchreiben 1 cycle with those values, Gespeichert[1] pulse 2 cycles after request, DatenRaus unchanged.
3. After reset, ch0 read and ch1 write raised in the same cycle, both held until served, then repeated -> first round order ch0, ch1; second round order ch0, ch1 again (pointer rotates); KANAELE=3 all requesting -> 0,1,2,0.
4. ZEITLIMIT=4, ch0 read, memory silent -> strobe high 4 cycles then low, Fehler[0] and Geladen[0] pulse together, DatenRaus=0; late SpeicherFertig ignored.
5. Ch0 asserts LeseAnfrage and SchreibAnfrage together -> write transaction then read transaction, Gespeichert[0] before Geladen[0].
6. Reset asserted mid-AKTIV (no clock edge) -> strobes, pulses and Speicher* outputs go 0 immediately; after release a pending ch1 request is granted before ch0 only if ch0 is idle (pointer reset).

Source files
------------

// File: rtl/speicher_arbiter.sv
// Round-robin memory arbiter: KANAELE requesters share one memory port, one
// transaction at a time, with an optional per-transaction completion timeout.
module speicher_arbiter #(
    parameter int KANAELE       = 2,
    parameter int DATEN_BREITE  = 32,
    parameter int ADRESS_BREITE = 32,
    parameter int ZEITLIMIT     = 255
) (
    input  logic                               Clock,
    input  logic                               Reset,
    input  logic [KANAELE-1:0]                 LeseAnfrage,
    input  logic [KANAELE-1:0]                 SchreibAnfrage,
    input  logic [KANAELE*ADRESS_BREITE-1:0]   Adresse,
    input  logic [KANAELE*DATEN_BREITE-1:0]    SchreibDaten,
    output logic [DATEN_BREITE-1:0]            DatenRaus,
    output logic [KANAELE-1:0]                 Geladen,
    output logic [KANAELE-1:0]                 Gespeichert,
    output logic [KANAELE-1:0]                 Fehler,
    output logic [ADRESS_BREITE-1:0]           SpeicherAdresse,
    output logic [DATEN_BREITE-1:0]            SpeicherSchreibDaten,
    output logic                               SpeicherLesen,
    output logic                               SpeicherSchreiben,
    input  logic [DATEN_BREITE-1:0]            SpeicherLeseDaten,
    input  logic                               SpeicherFertig
);

    localparam int IDX_W = (KANAELE > 1) ? $clog2(KANAELE) : 1;
    localparam int CNT_W = (ZEITLIMIT > 0) ? $clog2(ZEITLIMIT + 1) : 1;
    localparam logic [IDX_W:0]   KANAELE_L  = (IDX_W + 1)'(KANAELE);
    localparam logic [IDX_W-1:0] PTR_RESET  = IDX_W'(KANAELE - 1);
    localparam logic [CNT_W-1:0] LIMIT_L    = CNT_W'(ZEITLIMIT);
    localparam logic             TIMEOUT_EN = (ZEITLIMIT != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        FREI     = 2'd0,
        AKTIV    = 2'd1,
        QUITTUNG = 2'd2
    } zustand_t;

    zustand_t                  state_q, state_d;
    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic [IDX_W-1:0]          winner_q, winner_d;
    logic                      schreib_q, schreib_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ADRESS_BREITE-1:0]  adr_q, adr_d;
    logic [DATEN_BREITE-1:0]   wdat_q, wdat_d;
    logic [DATEN_BREITE-1:0]   rdat_q, rdat_d;
    logic                      lesen_q, lesen_d;
    logic                      schreiben_q, schreiben_d;
    logic [KANAELE-1:0]        geladen_q, geladen_d;
    logic [KANAELE-1:0]        gespeichert_q, gespeichert_d;
    logic [KANAELE-1:0]        fehler_q, fehler_d;

    logic [KANAELE-1:0]        anfrage_s;
    logic                      found_s;
    logic [IDX_W:0]            sum_s;
    logic [IDX_W-1:0]          cand_s;
    logic [CNT_W-1:0]          cnt_inc_s;

    assign anfrage_s = LeseAnfrage | SchreibAnfrage;
    assign cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Next-state, grant selection and registered-output computation.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        winner_d      = winner_q;
        schreib_d     = schreib_q;
        cnt_d         = cnt_q;
        adr_d         = adr_q;
        wdat_d        = wdat_q;
        rdat_d        = rdat_q;
        lesen_d       = lesen_q;
        schreiben_d   = schreiben_q;
        geladen_d     = '0;
        gespeichert_d = '0;
        fehler_d      = '0;
        found_s       = 1'b0;
        sum_s         = '0;
        cand_s        = '0;

        case (state_q)
            FREI: begin
                // Scan upward from the channel after the last winner, with wrap.
                for (int i = 1; i <= KANAELE; i++) begin
                    sum_s = {1'b0, ptr_q} + (IDX_W + 1)'(i);
                    if (sum_s >= KANAELE_L) begin
                        sum_s = sum_s - KANAELE_L;
                    end else begin
                        sum_s = sum_s;
                    end
                    cand_s = sum_s[IDX_W-1:0];
                    if (!found_s && anfrage_s[cand_s]) begin
                        found_s   = 1'b1;
                        winner_d  = cand_s;
                        adr_d     = Adresse[cand_s*ADRESS_BREITE +: ADRESS_BREITE];
                        wdat_d    = SchreibDaten[cand_s*DATEN_BREITE +: DATEN_BREITE];
                        schreib_d = SchreibAnfrage[cand_s];
                    end else begin
                        found_s = found_s;
                    end
                end
                if (found_s) begin
                    ptr_d       = winner_d;
                    cnt_d       = '0;
                    lesen_d     = ~schreib_d;
                    schreiben_d = schreib_d;
                    state_d     = AKTIV;
                end else begin
                    state_d = FREI;
                end
            end
            AKTIV: begin
                if (SpeicherFertig) begin
                    lesen_d     = 1'b0;
                    schreiben_d = 1'b0;
                    state_d     = QUITTUNG;
                    if (schreib_q) begin
                        gespeichert_d[winner_q] = 1'b1;
                    end else begin
                        geladen_d[winner_q] = 1'b1;
                        rdat_d              = SpeicherLeseDaten;
                    end
                end else if (TIMEOUT_EN && (cnt_inc_s == LIMIT_L)) begin
                    // Memory never answered: complete with an error flag.
                    lesen_d            = 1'b0;
                    schreiben_d        = 1'b0;
                    state_d            = QUITTUNG;
                    fehler_d[winner_q] = 1'b1;
                    if (schreib_q) begin
                        gespeichert_d[winner_q] = 1'b1;
                    end else begin
                        geladen_d[winner_q] = 1'b1;
                        rdat_d              = '0;
                    end
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            QUITTUNG: begin
                state_d = FREI;
            end
            default: begin
                lesen_d     = 1'b0;
                schreiben_d = 1'b0;
                state_d     = FREI;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q       <= FREI;
            ptr_q         <= PTR_RESET;
            winner_q      <= '0;
            schreib_q     <= 1'b0;
            cnt_q         <= '0;
            adr_q         <= '0;
            wdat_q        <= '0;
            rdat_q        <= '0;
            lesen_q       <= 1'b0;
            schreiben_q   <= 1'b0;
            geladen_q     <= '0;
            gespeichert_q <= '0;
            fehler_q      <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            winner_q      <= winner_d;
            schreib_q     <= schreib_d;
            cnt_q         <= cnt_d;
            adr_q         <= adr_d;
            wdat_q        <= wdat_d;
            rdat_q        <= rdat_d;
            lesen_q       <= lesen_d;
            schreiben_q   <= schreiben_d;
            geladen_q     <= geladen_d;
            gespeichert_q <= gespeichert_d;
            fehler_q      <= fehler_d;
        end
    end

    assign DatenRaus            = rdat_q;
    assign Geladen              = geladen_q;
    assign Gespeichert          = gespeichert_q;
    assign Fehler               = fehler_q;
    assign SpeicherAdresse      = adr_q;
    assign SpeicherSchreibDaten = wdat_q;
    assign SpeicherLesen        = lesen_q;
    assign SpeicherSchreiben    = schreiben_q;

endmodule
